// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the access-error rule.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    STORE_RD = 3'd2,
    STORE_WR = 3'd3,
    RESP     = 3'd4
  } state_t;

  // Reserved size is always an error; alignment only matters when checking is enabled.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lo,
                                      input logic check_align);
    access_err = (size == SZ_RSVD) ||
                 (check_align && (((size == SZ_HALF) && lo[0]) ||
                                  ((size == SZ_WORD) && (lo != 2'b00))));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: little-endian load extract with zero/sign extension, and read-modify-write store merge.
// Purely combinational; no state, no backpressure.
module lsu_align (
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);
  import lsu_pkg::*;

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = rdata[{lane, 3'b000} +: 8];
    half_v     = lane[1] ? rdata[31:16] : rdata[15:0];
    load_data  = rdata;
    merge_data = rdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sext & byte_v[7]}}, byte_v};
        merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{sext & half_v[15]}}, half_v};
        if (lane[1]) merge_data[31:16] = wdata[15:0];
        else         merge_data[15:0]  = wdata[15:0];
      end
      SZ_WORD: merge_data = wdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: load 2 cycles, word store 2, sub-word store 3 (read-modify-write), errors 1.
// Accepts only in IDLE; the response is held until resp_ready, then returns to IDLE.
module load_store_unit #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);
  import lsu_pkg::*;

  state_t      state;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [1:0]  lane_q;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign req_err    = access_err(req_size, req_addr[1:0], CHECK_ALIGN);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_write  = (state == STORE_WR);

  // mem_wdata holds the right-aligned store data until STORE_RD overwrites it with the merged word.
  lsu_align u_align (
    .size       (size_q),
    .sext       (sext_q),
    .lane       (lane_q),
    .rdata      (mem_rdata),
    .wdata      (mem_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      size_q     <= SZ_BYTE;
      sext_q     <= 1'b0;
      lane_q     <= 2'b00;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q     <= req_size;
            sext_q     <= req_signed;
            lane_q     <= req_addr[1:0];
            resp_rdata <= '0;
            resp_err   <= req_err;
            if (req_err) begin
              state <= RESP;
            end else begin
              mem_addr <= {2'b00, req_addr[31:2]};
              if (req_we) begin
                mem_wdata <= req_wdata;
                state     <= (req_size == SZ_WORD) ? STORE_WR : STORE_RD;
              end else begin
                state <= LOAD;
              end
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          state      <= RESP;
        end
        STORE_RD: begin
          mem_wdata <= merge_data;
          state     <= STORE_WR;
        end
        STORE_WR: state <= RESP;
        RESP: begin
          if (resp_ready) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: a behavioural access model predicts every cycle's handshake, memory and response
// values; one negedge monitor compares them against the DUT.
module tb_load_store_unit;

  localparam bit CHK = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write;

  logic [31:0] dmem    [0:15];
  logic [31:0] ref_mem [0:15];

  logic        exp_ready, exp_rvalid, exp_mw, exp_err;
  logic        exp_chk_rsp, exp_chk_mem, exp_chk_wd;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [31:0] last_rd, last_nw;
  logic        last_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit #(.CHECK_ALIGN(CHK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = (mem_addr < 32'd16) ? dmem[mem_addr[3:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_write && (mem_addr < 32'd16)) dmem[mem_addr[3:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_rvalid});
    chk("mem_write", {31'd0, mem_write}, {31'd0, exp_mw});
    if (exp_chk_rsp) begin
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
    end
    if (exp_chk_mem) chk("mem_addr", mem_addr, exp_addr);
    if (exp_chk_wd)  chk("mem_wdata", mem_wdata, exp_wdata);
  end

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) ||
           (CHK && (((size == 2'd1) && (addr % 32'd2 != 0)) ||
                    ((size == 2'd2) && (addr % 32'd4 != 0))));
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    return (size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
  endfunction

  function automatic int lane_shift(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd0) return 8 * int'(addr % 32'd4);
    return 16 * int'((addr / 32'd2) % 32'd2);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic sgn, input logic [31:0] addr);
    logic [31:0] mask, v;
    if (size == 2'd2) return w;
    mask = lane_mask(size);
    v = (w >> lane_shift(size, addr)) & mask;
    if (sgn && ((v & ((mask >> 1) + 32'd1)) != 0)) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] size,
                                              input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    if (size == 2'd2) return wd;
    mask = lane_mask(size);
    sh = lane_shift(size, addr);
    return (old & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  task automatic idle_exp();
    exp_ready = 1'b1; exp_rvalid = 1'b0; exp_mw = 1'b0;
    exp_chk_rsp = 1'b0; exp_chk_mem = 1'b0; exp_chk_wd = 1'b0;
  endtask

  task automatic reset_exp();
    idle_exp();
    exp_chk_rsp = 1'b1; exp_rdata = 32'd0; exp_err = 1'b0;
    exp_chk_mem = 1'b1; exp_addr = 32'd0;
    exp_chk_wd  = 1'b1; exp_wdata = 32'd0;
  endtask

  // One full access; entered and left just after a rising edge with the DUT idle.
  task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, input logic stray);
    int idx, lat, wcyc;
    logic err;
    logic [31:0] rd, nw;
    idx  = int'(addr >> 2);
    err  = model_err(size, addr);
    rd   = (err || we) ? 32'd0 : model_load(ref_mem[idx], size, sgn, addr);
    nw   = model_store(ref_mem[idx], size, addr, wd);
    lat  = err ? 1 : (!we ? 2 : ((size == 2'd2) ? 2 : 3));
    wcyc = (size == 2'd2) ? 1 : 2;
    last_rd = rd; last_nw = nw; last_err = err;

    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    idle_exp();
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c < lat; c++) begin
      exp_ready = 1'b0; exp_rvalid = 1'b0;
      exp_mw = we && (c == wcyc);
      exp_chk_mem = 1'b1; exp_addr = 32'(idx);
      exp_chk_wd = exp_mw; exp_wdata = nw;
      @(posedge clk); #1;
    end
    if (we && !err) ref_mem[idx] = nw;
    exp_chk_mem = 1'b0; exp_chk_wd = 1'b0; exp_mw = 1'b0; exp_ready = 1'b0;
    exp_rvalid = 1'b1; exp_chk_rsp = 1'b1; exp_rdata = rd; exp_err = err;
    if (stray) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h14; req_wdata = 32'hCAFE_F00D;
    end
    repeat (hold) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    idle_exp();
    chk("mem_word", dmem[idx], ref_mem[idx]);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dmem[i] = 32'h1111_1111 * 32'(i);
      ref_mem[i] = dmem[i];
    end
    dmem[3] = 32'h8899_AABB; ref_mem[3] = 32'h8899_AABB;
    reset_exp();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_exp();
    @(posedge clk); #1;

    // Signed byte load of lane 1 of 0x8899AABB
    access(1'b0, 2'd0, 1'b1, 32'h0D, 32'd0, 0, 1'b0);
    chk("pin_sbyte", last_rd, 32'hFFFF_FFAA);
    // Half store into the upper lane of word 3
    access(1'b1, 2'd1, 1'b0, 32'h0E, 32'h0000_1234, 0, 1'b0);
    chk("pin_hstore_model", last_nw, 32'h1234_AABB);
    chk("pin_hstore_mem", dmem[3], 32'h1234_AABB);
    // Error responses
    access(1'b0, 2'd2, 1'b0, 32'h06, 32'd0, 0, 1'b0);
    chk("pin_err_word", {31'd0, last_err}, 32'd1);
    access(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFF_FFFF, 0, 1'b0);
    access(1'b0, 2'd1, 1'b1, 32'h11, 32'd0, 1, 1'b0);
    // Held response with a stray request that must be ignored
    access(1'b0, 2'd2, 1'b0, 32'h0C, 32'd0, 3, 1'b1);
    chk("pin_word", last_rd, 32'h1234_AABB);
    access(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, 0, 1'b0);
    chk("pin_stray_word", last_rd, 32'h5555_5555);
    // Lane sweep and sign extension
    for (int a = 12; a < 16; a++) access(1'b0, 2'd0, 1'b0, 32'(a), 32'd0, 0, 1'b0);
    access(1'b0, 2'd1, 1'b1, 32'h0E, 32'd0, 0, 1'b0);
    access(1'b0, 2'd1, 1'b1, 32'h0C, 32'd0, 2, 1'b0);
    chk("pin_shalf", last_rd, 32'hFFFF_AABB);
    access(1'b1, 2'd0, 1'b0, 32'h1B, 32'hFFFF_FF5A, 0, 1'b0);
    chk("pin_bstore", dmem[6], 32'h5A66_6666);
    access(1'b0, 2'd0, 1'b1, 32'h1B, 32'd0, 0, 1'b0);
    access(1'b1, 2'd2, 1'b0, 32'h18, 32'hA5A5_0F0F, 1, 1'b0);
    access(1'b0, 2'd1, 1'b0, 32'h1A, 32'd0, 0, 1'b0);

    // Reset pulsed during STORE_RD of a byte store
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h0000_00EE;
    idle_exp();
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    reset_exp();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    idle_exp();
    repeat (4) begin @(posedge clk); #1; end
    chk("rst_mem_unchanged", dmem[8], ref_mem[8]);
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
